lif_neuron_array: RTL
=====================

LIF_NEURON_ARRAY -- requirements
Module: lif_neuron_array

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of independent neuron channels.
REQ-002 SHALL have parameter W, default 8: membrane-state, input-current and threshold width.
REQ-003 SHALL have parameter REFRAC, default 4: refractory length in enabled cycles, 0..255.
REQ-004 SHALL have parameter CNT_W, default 16: spike-counter width.
REQ-005 SHALL have port clk  in  1  sole clock, all state updates on its rising edge.
REQ-006 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-007 SHALL have port ena  in  1  update enable; 0 = all state held.
REQ-008 SHALL have port cur_in  in  N_CH*W  per-channel input current, channel i at bits [i*W +: W].
REQ-009 SHALL have port threshold  in  W  firing threshold shared by all channels.
REQ-010 SHALL have port leak_shift  in  3  leak shift amount; 0 = no leak.
REQ-011 SHALL have port mode  in  1  post-spike mode; 0 = reset-to-zero, 1 = subtract-threshold.
REQ-012 SHALL have port clr_cnt  in  1  synchronous clear of spike_count.
REQ-013 SHALL have port state_out  out  N_CH*W  registered membrane state per channel.
REQ-014 SHALL have port spike  out  N_CH  registered per-channel spike pulse.
REQ-015 SHALL have port spike_count  out  CNT_W  saturating total spike count.

Function
REQ-016 SHALL update every channel in parallel on each rising clk edge with ena=1; with ena=0, state, refractory counters and spike_count SHALL hold and spike SHALL be 0 after that edge.
REQ-017 SHALL hold a per-channel refractory counter; channel is refractory while counter != 0.
REQ-018 Refractory channel on enabled edge: counter decrements by 1, state holds, cur_in ignored, spike[i]=0.
REQ-019 Non-refractory channel: leaked = state - (state >> leak_shift), or leaked = state when leak_shift = 0.
REQ-020 sum = leaked + cur_in[i], computed in W+1 bits, saturated to 2^W-1.
REQ-021 If sum >= threshold: spike[i]=1 for exactly one cycle; state = 0 (mode=0) or sum - threshold (mode=1); counter = REFRAC.
REQ-022 If sum < threshold: state = sum, spike[i]=0.
REQ-023 threshold = 0 SHALL make every non-refractory enabled channel fire each update.
REQ-024 REFRAC = 0 SHALL allow a channel to fire on consecutive enabled edges.
REQ-025 Spike latency: spike and the new state SHALL appear together, one edge after the inputs that caused them are sampled.
REQ-026 spike_count SHALL add the number of spikes set on that edge (0..N_CH), saturating at 2^CNT_W-1.
REQ-027 clr_cnt=1 SHALL set spike_count to 0 on the next edge regardless of ena; clear wins over simultaneous increment.
REQ-028 mode, threshold and leak_shift changes SHALL take effect on the next enabled edge; no stored config.

Reset
REQ-029 rst_n=0 SHALL immediately and asynchronously set state_out, spike, spike_count and all refractory counters to 0, including mid-refractory.
REQ-030 After rst_n release, the first enabled edge SHALL integrate normally; no channel is refractory.

Verification
REQ-031 Reset: drive rst_n=0 mid-run with nonzero state -> all outputs 0 without waiting for a clk edge.
REQ-032 Integrate/refractory: N_CH=4, W=8, REFRAC=4, ch0 cur=20, thr=100, leak_shift=0, mode=0 -> state 20,40,60,80, then 0 with spike0=1 on the 5th edge; 0 for 4 edges; then 20.
REQ-033 Leak: cur=16, thr=255, leak_shift=2 -> state 16,28,37,...; converges to 64; never spikes.
REQ-034 Subtract mode: cur=60, thr=100, mode=1 -> state 60, then 20 with spike; 20 held 4 edges; then 80, then 40 with spike.
REQ-035 Saturation/count: all channels cur=255, thr=255, REFRAC=0 -> every edge all spike=1, spike_count +4 per edge; clr_cnt asserted with spikes -> spike_count 0; count saturates at 65535.
REQ-036 Enable hold: deassert ena mid-integration at state 60 for 3 cycles -> state 60 held, spike 0, refractory counter unchanged; resumes on ena=1.

Source files
------------

// File: rtl/lif_neuron_array.sv
`default_nettype none
// lif_neuron_array: N_CH parallel leaky integrate-and-fire neurons with a shared threshold,
// per-channel refractory timers and a saturating total spike counter.
module lif_neuron_array #(
  parameter int N_CH   = 4,
  parameter int W      = 8,
  parameter int REFRAC = 4,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic [N_CH*W-1:0]   cur_in,
  input  logic [W-1:0]        threshold,
  input  logic [2:0]          leak_shift,
  input  logic                mode,
  input  logic                clr_cnt,
  output logic [N_CH*W-1:0]   state_out,
  output logic [N_CH-1:0]     spike,
  output logic [CNT_W-1:0]    spike_count
);

  localparam logic [7:0] c_refrac = 8'(REFRAC);
  localparam int         PW       = $clog2(N_CH + 1);
  localparam int         CW1      = CNT_W + 1;

  logic [N_CH-1:0][W-1:0] state_q, state_d;
  logic [N_CH-1:0][7:0]   refr_q, refr_d;
  logic [N_CH-1:0]        spike_q;
  logic [N_CH-1:0]        fire;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [PW-1:0]          pop;
  logic [CNT_W:0]         cnt_sum;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [W-1:0] st, cur, leaked, sat;
    logic [W:0]   sum;
    logic         refr;

    assign st     = state_q[i];
    assign cur    = cur_in[i*W +: W];
    // A shift of zero would cancel the whole state, so it means "no leak".
    assign leaked = (leak_shift == 3'd0) ? st : st - (st >> leak_shift);
    assign sum    = {1'b0, leaked} + {1'b0, cur};
    assign sat    = sum[W] ? {W{1'b1}} : sum[W-1:0];
    assign refr   = (refr_q[i] != 8'd0);
    assign fire[i] = !refr && (sat >= threshold);

    assign state_d[i] = refr    ? st :
                        fire[i] ? (mode ? sat - threshold : '0) :
                                  sat;
    assign refr_d[i]  = refr    ? refr_q[i] - 8'd1 :
                        fire[i] ? c_refrac : 8'd0;
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < N_CH; i++) begin
      pop = pop + PW'(fire[i]);
    end
  end

  assign cnt_sum = {1'b0, cnt_q} + CW1'(pop);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_cnt) begin
      cnt_d = '0;
    end else if (ena) begin
      cnt_d = cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= '0;
      refr_q  <= '0;
      spike_q <= '0;
      cnt_q   <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (ena) begin
        state_q <= state_d;
        refr_q  <= refr_d;
        spike_q <= fire;
      end else begin
        spike_q <= '0;
      end
    end
  end

  assign state_out   = state_q;
  assign spike       = spike_q;
  assign spike_count = cnt_q;

endmodule
`default_nettype wire
